// File: rtl/tlb_refill.sv
// Small fully-associative TLB with dual combinational lookup ports and a single
// outstanding page-walk refill engine (IDLE -> WALK -> DONE).
module tlb_refill #(
   parameter int unsigned ENTRIES   = 8,
   parameter int unsigned PTE_WIDTH = 44
) (
   input  logic                 clk,
   input  logic                 rst,
   // fetch lookup
   input  logic [31:0]          i_fetch_va,
   input  logic                 i_fetch_vld,
   output logic [PTE_WIDTH-1:0] o_fetch_pte,
   output logic                 fetch_hit,
   // data lookup
   input  logic [31:0]          i_tlb_va,
   input  logic                 i_tlb_vld,
   output logic [PTE_WIDTH-1:0] o_tlb_pte,
   output logic                 tlb_hit,
   // walker
   output logic                 o_walk_req,
   output logic [19:0]          o_walk_vpn,
   input  logic                 i_walk_ack,
   input  logic [PTE_WIDTH-1:0] i_walk_pte,
   input  logic                 i_walk_fault,
   // control / status
   input  logic                 i_flush,
   output logic                 o_busy,
   output logic                 o_fill_done,
   output logic                 o_fault
);

   localparam int unsigned IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam int unsigned VPN_LO = 23;
   localparam int unsigned VPN_HI = 42;

   typedef enum logic [1:0] {StIdle, StWalk, StDone} state_e;

   state_e               state_q, state_d;
   logic [PTE_WIDTH-1:0] pte_q [ENTRIES];
   logic [ENTRIES-1:0]   valid_q;
   logic [IDX_W-1:0]     victim_q;
   logic [19:0]          walk_vpn_q;
   logic                 fault_q;

   // Page offsets never take part in translation.
   logic unused_va_bits;
   assign unused_va_bits = ^{i_tlb_va[11:0], i_fetch_va[11:0]};

   function automatic logic pte_match(input logic                 entry_vld,
                                      input logic [PTE_WIDTH-1:0] pte,
                                      input logic [19:0]          vpn);
      return entry_vld && (pte[VPN_HI:VPN_LO] == vpn) && pte[1] && pte[2];
   endfunction

   // ---------------------------------------------------------------------------
   // Lookup: descending scan so the lowest matching index wins
   // ---------------------------------------------------------------------------
   logic                 tlb_found, fetch_found;
   logic [PTE_WIDTH-1:0] tlb_sel, fetch_sel;

   always_comb begin
      tlb_found   = 1'b0;
      fetch_found = 1'b0;
      tlb_sel     = '0;
      fetch_sel   = '0;
      for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
         if (pte_match(valid_q[i], pte_q[i], i_tlb_va[31:12])) begin
            tlb_found = 1'b1;
            tlb_sel   = pte_q[i];
         end
         if (pte_match(valid_q[i], pte_q[i], i_fetch_va[31:12])) begin
            fetch_found = 1'b1;
            fetch_sel   = pte_q[i];
         end
      end
   end

   assign tlb_hit     = i_tlb_vld & tlb_found;
   assign fetch_hit   = i_fetch_vld & fetch_found;
   assign o_tlb_pte   = tlb_hit ? tlb_sel : '0;
   assign o_fetch_pte = fetch_hit ? fetch_sel : '0;

   // ---------------------------------------------------------------------------
   // Miss detection and walk response qualification
   // ---------------------------------------------------------------------------
   logic        tlb_miss, fetch_miss, start_walk;
   logic        ack_ok, pte_good, install, reject;
   logic [19:0] miss_vpn;

   always_comb begin
      tlb_miss   = i_tlb_vld & ~tlb_found;
      fetch_miss = i_fetch_vld & ~fetch_found;
      miss_vpn   = tlb_miss ? i_tlb_va[31:12] : i_fetch_va[31:12];
      start_walk = (state_q == StIdle) & (tlb_miss | fetch_miss) & ~i_flush;
      // A flush in the same cycle as the ack wins; the response is dropped.
      ack_ok     = (state_q == StWalk) & i_walk_ack & ~i_flush;
      pte_good   = ~i_walk_fault & (i_walk_pte[2:1] == 2'b11);
      install    = ack_ok & pte_good;
      reject     = ack_ok & ~pte_good;
   end

   // ---------------------------------------------------------------------------
   // Fill target: existing entry for this VPN, else lowest free, else victim
   // ---------------------------------------------------------------------------
   logic                 same_found, free_found, use_victim;
   logic [IDX_W-1:0]     same_idx, free_idx, target_idx, victim_nxt;
   logic [PTE_WIDTH-1:0] wr_pte;

   always_comb begin
      same_found = 1'b0;
      free_found = 1'b0;
      same_idx   = '0;
      free_idx   = '0;
      for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
         if (valid_q[i] && (pte_q[i][VPN_HI:VPN_LO] == walk_vpn_q)) begin
            same_found = 1'b1;
            same_idx   = IDX_W'(i);
         end
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
      use_victim = ~same_found & ~free_found;
      target_idx = same_found ? same_idx : (free_found ? free_idx : victim_q);
      victim_nxt = (victim_q == IDX_W'(ENTRIES - 1)) ? '0 : victim_q + IDX_W'(1);
      // The walker's VPN field is not trusted; the requested VPN is installed.
      wr_pte     = i_walk_pte;
      wr_pte[VPN_HI:VPN_LO] = walk_vpn_q;
   end

   // ---------------------------------------------------------------------------
   // FSM: state register, next state, outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (start_walk) state_d = StWalk;
         StWalk: if (ack_ok) state_d = pte_good ? StDone : StIdle;
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (i_flush) state_d = StIdle;
   end

   always_comb begin
      o_walk_req  = (state_q == StWalk);
      o_fill_done = (state_q == StDone);
      o_busy      = (state_q == StWalk) | (state_q == StDone);
      o_fault     = fault_q;
      o_walk_vpn  = walk_vpn_q;
   end

   // ---------------------------------------------------------------------------
   // Entry storage, victim pointer, walk VPN and fault pulse
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            pte_q[i] <= '0;
         end
         valid_q    <= '0;
         victim_q   <= '0;
         walk_vpn_q <= '0;
         fault_q    <= 1'b0;
      end else begin
         fault_q <= reject;
         if (i_flush) begin
            valid_q  <= '0;
            victim_q <= '0;
         end else if (install) begin
            pte_q[target_idx]   <= wr_pte;
            valid_q[target_idx] <= 1'b1;
            if (use_victim) victim_q <= victim_nxt;
         end
         if (start_walk) walk_vpn_q <= miss_vpn;
      end
   end

endmodule

// File: tb/tb_tlb_refill.sv
// Directed self-checking bench for tlb_refill (default ENTRIES=8, PTE_WIDTH=44).
module tb_tlb_refill;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] i_fetch_va = '0;
   logic        i_fetch_vld = 1'b0;
   logic [43:0] o_fetch_pte;
   logic        fetch_hit;
   logic [31:0] i_tlb_va = '0;
   logic        i_tlb_vld = 1'b0;
   logic [43:0] o_tlb_pte;
   logic        tlb_hit;
   logic        o_walk_req;
   logic [19:0] o_walk_vpn;
   logic        i_walk_ack = 1'b0;
   logic [43:0] i_walk_pte = '0;
   logic        i_walk_fault = 1'b0;
   logic        i_flush = 1'b0;
   logic        o_busy, o_fill_done, o_fault;

   int n_run  = 0;
   int n_fail = 0;

   tlb_refill #(.ENTRIES(8), .PTE_WIDTH(44)) dut (
      .clk(clk), .rst(rst),
      .i_fetch_va(i_fetch_va), .i_fetch_vld(i_fetch_vld),
      .o_fetch_pte(o_fetch_pte), .fetch_hit(fetch_hit),
      .i_tlb_va(i_tlb_va), .i_tlb_vld(i_tlb_vld),
      .o_tlb_pte(o_tlb_pte), .tlb_hit(tlb_hit),
      .o_walk_req(o_walk_req), .o_walk_vpn(o_walk_vpn),
      .i_walk_ack(i_walk_ack), .i_walk_pte(i_walk_pte), .i_walk_fault(i_walk_fault),
      .i_flush(i_flush),
      .o_busy(o_busy), .o_fill_done(o_fill_done), .o_fault(o_fault)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [43:0] make_pte(input logic [19:0] vpn, input logic [19:0] ppn,
                                            input logic [2:0] bits);
      return {1'b0, vpn, ppn, bits};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full miss/walk/install sequence on the data port, ending back in IDLE.
   task automatic do_fill(input logic [19:0] vpn, input logic [19:0] ppn);
      i_tlb_va  = {vpn, 12'h000};
      i_tlb_vld = 1'b1;
      step();
      i_tlb_vld  = 1'b0;
      i_walk_ack = 1'b1;
      i_walk_pte = make_pte(vpn, ppn, 3'b111);
      step();
      i_walk_ack = 1'b0;
      step();
   endtask

   task automatic test_reset();
      i_tlb_va  = 32'h0000_2ABC;
      i_tlb_vld = 1'b1;
      #1 rst = 1'b1;
      step();
      step();
      n_run++; if (o_walk_req !== 1'b0) begin n_fail++;
         $display("FAIL reset_walk_req: got %b want 0", o_walk_req); end
      n_run++; if (o_busy !== 1'b0 || o_fill_done !== 1'b0 || o_fault !== 1'b0) begin n_fail++;
         $display("FAIL reset_status: got busy=%b done=%b fault=%b want 0 0 0",
                  o_busy, o_fill_done, o_fault); end
      n_run++; if (tlb_hit !== 1'b0 || o_tlb_pte !== 44'h0) begin n_fail++;
         $display("FAIL reset_tlb_lookup: got hit=%b pte=%h want 0/0", tlb_hit, o_tlb_pte); end
      n_run++; if (o_walk_vpn !== 20'h0) begin n_fail++;
         $display("FAIL reset_walk_vpn: got %h want 0", o_walk_vpn); end
      i_tlb_vld = 1'b0;
      rst       = 1'b0;
      step();
   endtask

   task automatic test_first_fill();
      i_tlb_va  = 32'h0000_2ABC;
      i_tlb_vld = 1'b1;
      #1;
      n_run++; if (tlb_hit !== 1'b0) begin n_fail++;
         $display("FAIL miss_hit: got %b want 0", tlb_hit); end
      step();
      n_run++; if (o_walk_req !== 1'b1 || o_walk_vpn !== 20'h00002) begin n_fail++;
         $display("FAIL walk_req: got req=%b vpn=%h want 1/00002", o_walk_req, o_walk_vpn); end
      n_run++; if (o_busy !== 1'b1) begin n_fail++;
         $display("FAIL walk_busy: got %b want 1", o_busy); end
      i_walk_ack = 1'b1;
      i_walk_pte = make_pte(20'h00002, 20'h00005, 3'b111);
      step();
      i_walk_ack = 1'b0;
      n_run++; if (o_fill_done !== 1'b1 || o_walk_req !== 1'b0) begin n_fail++;
         $display("FAIL fill_done: got done=%b req=%b want 1/0", o_fill_done, o_walk_req); end
      n_run++; if (tlb_hit !== 1'b1 || o_tlb_pte[22:3] !== 20'h00005) begin n_fail++;
         $display("FAIL fill_hit: got hit=%b ppn=%h want 1/00005", tlb_hit, o_tlb_pte[22:3]); end
      step();
      n_run++; if (o_fill_done !== 1'b0 || o_busy !== 1'b0) begin n_fail++;
         $display("FAIL done_len: got done=%b busy=%b want 0/0", o_fill_done, o_busy); end
      i_tlb_vld = 1'b0;
   endtask

   task automatic test_wrap();
      i_flush = 1'b1;
      step();
      i_flush = 1'b0;
      for (int k = 0; k < 9; k++) do_fill(20'h10 + 20'(k), 20'h100 + 20'(k));
      i_fetch_vld = 1'b1;
      i_fetch_va  = 32'h0001_0000;
      #1;
      n_run++; if (fetch_hit !== 1'b0 || o_fetch_pte !== 44'h0) begin n_fail++;
         $display("FAIL wrap_first_evicted: got hit=%b pte=%h want 0/0", fetch_hit, o_fetch_pte); end
      i_fetch_va = 32'h0001_8000;
      #1;
      n_run++; if (fetch_hit !== 1'b1 || o_fetch_pte[22:3] !== 20'h00108) begin n_fail++;
         $display("FAIL wrap_last: got hit=%b ppn=%h want 1/00108", fetch_hit, o_fetch_pte[22:3]); end
      i_fetch_va = 32'h0001_1000;
      #1;
      n_run++; if (fetch_hit !== 1'b1 || o_fetch_pte[22:3] !== 20'h00101) begin n_fail++;
         $display("FAIL wrap_second: got hit=%b ppn=%h want 1/00101", fetch_hit, o_fetch_pte[22:3]); end
      i_fetch_vld = 1'b0;
      do_fill(20'h19, 20'h109);
      i_fetch_vld = 1'b1;
      i_fetch_va  = 32'h0001_1000;
      #1;
      n_run++; if (fetch_hit !== 1'b0) begin n_fail++;
         $display("FAIL ptr_advance_evict: got %b want 0", fetch_hit); end
      i_fetch_va = 32'h0001_2000;
      #1;
      n_run++; if (fetch_hit !== 1'b1) begin n_fail++;
         $display("FAIL ptr_advance_keep: got %b want 1", fetch_hit); end
      i_fetch_vld = 1'b0;
   endtask

   task automatic test_vpn_force();
      i_tlb_va  = 32'h0002_0000;
      i_tlb_vld = 1'b1;
      step();
      i_tlb_vld  = 1'b0;
      i_walk_ack = 1'b1;
      i_walk_pte = make_pte(20'h007FF, 20'h00222, 3'b111);
      step();
      i_walk_ack = 1'b0;
      step();
      i_tlb_vld = 1'b1;
      #1;
      n_run++; if (tlb_hit !== 1'b1 || o_tlb_pte[42:23] !== 20'h00020) begin n_fail++;
         $display("FAIL vpn_forced: got hit=%b vpn=%h want 1/00020", tlb_hit, o_tlb_pte[42:23]); end
      i_tlb_va = 32'h007F_F000;
      #1;
      n_run++; if (tlb_hit !== 1'b0) begin n_fail++;
         $display("FAIL vpn_walker_field: got %b want 0", tlb_hit); end
      i_tlb_va = 32'h0001_2000;
      #1;
      n_run++; if (tlb_hit !== 1'b0) begin n_fail++;
         $display("FAIL victim_entry2: got %b want 0", tlb_hit); end
      i_tlb_va = 32'h0001_3000;
      #1;
      n_run++; if (tlb_hit !== 1'b1) begin n_fail++;
         $display("FAIL victim_keep3: got %b want 1", tlb_hit); end
      i_tlb_vld = 1'b0;
   endtask

   task automatic test_fault();
      for (int k = 0; k < 2; k++) begin
         i_tlb_va  = 32'h0003_0000;
         i_tlb_vld = 1'b1;
         step();
         i_tlb_vld    = 1'b0;
         i_walk_ack   = 1'b1;
         i_walk_fault = (k == 0);
         i_walk_pte   = make_pte(20'h00030, 20'h00333, (k == 0) ? 3'b111 : 3'b011);
         step();
         i_walk_ack   = 1'b0;
         i_walk_fault = 1'b0;
         n_run++; if (o_fault !== 1'b1 || o_busy !== 1'b0 || o_fill_done !== 1'b0) begin n_fail++;
            $display("FAIL fault_pulse[%0d]: got fault=%b busy=%b done=%b want 1 0 0",
                     k, o_fault, o_busy, o_fill_done); end
         step();
         n_run++; if (o_fault !== 1'b0) begin n_fail++;
            $display("FAIL fault_len[%0d]: got %b want 0", k, o_fault); end
         i_fetch_va  = 32'h0003_0000;
         i_fetch_vld = 1'b1;
         #1;
         n_run++; if (fetch_hit !== 1'b0) begin n_fail++;
            $display("FAIL fault_no_install[%0d]: got %b want 0", k, fetch_hit); end
         i_fetch_vld = 1'b0;
      end
   endtask

   task automatic test_flush();
      i_tlb_va  = 32'h0004_0000;
      i_tlb_vld = 1'b1;
      step();
      i_tlb_vld = 1'b0;
      n_run++; if (o_walk_req !== 1'b1) begin n_fail++;
         $display("FAIL flush_pre_walk: got %b want 1", o_walk_req); end
      i_walk_ack = 1'b1;
      i_walk_pte = make_pte(20'h00040, 20'h00444, 3'b111);
      i_flush    = 1'b1;
      step();
      i_walk_ack = 1'b0;
      i_flush    = 1'b0;
      n_run++; if (o_walk_req !== 1'b0 || o_busy !== 1'b0 || o_fill_done !== 1'b0) begin n_fail++;
         $display("FAIL flush_state: got req=%b busy=%b done=%b want 0 0 0",
                  o_walk_req, o_busy, o_fill_done); end
      i_fetch_vld = 1'b1;
      i_fetch_va  = 32'h0004_0000;
      #1;
      n_run++; if (fetch_hit !== 1'b0) begin n_fail++;
         $display("FAIL flush_no_install: got %b want 0", fetch_hit); end
      i_fetch_va = 32'h0001_3000;
      #1;
      n_run++; if (fetch_hit !== 1'b0) begin n_fail++;
         $display("FAIL flush_cleared: got %b want 0", fetch_hit); end
      i_fetch_vld = 1'b0;
      // A stray ack while idle must not start or complete anything.
      i_walk_ack = 1'b1;
      i_walk_pte = make_pte(20'h00041, 20'h00444, 3'b111);
      step();
      i_walk_ack = 1'b0;
      n_run++; if (o_fill_done !== 1'b0 || o_busy !== 1'b0) begin n_fail++;
         $display("FAIL idle_ack: got done=%b busy=%b want 0/0", o_fill_done, o_busy); end
   endtask

   task automatic test_dual_miss();
      i_tlb_va    = 32'h0005_0000;
      i_fetch_va  = 32'h0006_0000;
      i_tlb_vld   = 1'b1;
      i_fetch_vld = 1'b1;
      step();
      n_run++; if (o_walk_req !== 1'b1 || o_walk_vpn !== 20'h00050) begin n_fail++;
         $display("FAIL dual_data_first: got req=%b vpn=%h want 1/00050", o_walk_req, o_walk_vpn); end
      i_walk_ack = 1'b1;
      i_walk_pte = make_pte(20'h00050, 20'h0000A, 3'b111);
      step();
      i_walk_ack = 1'b0;
      n_run++; if (tlb_hit !== 1'b1 || fetch_hit !== 1'b0 || o_tlb_pte[22:3] !== 20'h0000A)
      begin n_fail++;
         $display("FAIL dual_data_done: got thit=%b fhit=%b ppn=%h want 1 0 0000a",
                  tlb_hit, fetch_hit, o_tlb_pte[22:3]); end
      i_tlb_vld = 1'b0;
      step();
      n_run++; if (o_busy !== 1'b0) begin n_fail++;
         $display("FAIL dual_idle_gap: got %b want 0", o_busy); end
      step();
      n_run++; if (o_walk_req !== 1'b1 || o_walk_vpn !== 20'h00060) begin n_fail++;
         $display("FAIL dual_fetch_retry: got req=%b vpn=%h want 1/00060", o_walk_req, o_walk_vpn); end
      i_walk_ack = 1'b1;
      i_walk_pte = make_pte(20'h00060, 20'h0000B, 3'b111);
      step();
      i_walk_ack = 1'b0;
      n_run++; if (fetch_hit !== 1'b1 || o_fetch_pte[22:3] !== 20'h0000B || o_fill_done !== 1'b1)
      begin n_fail++;
         $display("FAIL dual_fetch_done: got hit=%b ppn=%h done=%b want 1 0000b 1",
                  fetch_hit, o_fetch_pte[22:3], o_fill_done); end
      i_fetch_vld = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_walk();
      i_tlb_va  = 32'h0007_0000;
      i_tlb_vld = 1'b1;
      step();
      i_tlb_vld = 1'b0;
      #1 rst = 1'b1;
      #1;
      n_run++; if (o_walk_req !== 1'b0 || o_busy !== 1'b0 || o_walk_vpn !== 20'h0) begin n_fail++;
         $display("FAIL rst_async: got req=%b busy=%b vpn=%h want 0 0 0",
                  o_walk_req, o_busy, o_walk_vpn); end
      step();
      rst        = 1'b0;
      i_walk_ack = 1'b1;
      i_walk_pte = make_pte(20'h00070, 20'h00777, 3'b111);
      step();
      i_walk_ack = 1'b0;
      n_run++; if (o_fill_done !== 1'b0 || o_busy !== 1'b0) begin n_fail++;
         $display("FAIL rst_late_ack: got done=%b busy=%b want 0/0", o_fill_done, o_busy); end
      i_tlb_va  = 32'h0005_0000;
      i_tlb_vld = 1'b1;
      #1;
      n_run++; if (tlb_hit !== 1'b0) begin n_fail++;
         $display("FAIL rst_cleared: got %b want 0", tlb_hit); end
      i_tlb_vld = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_first_fill();
      test_wrap();
      test_vpn_force();
      test_fault();
      test_flush();
      test_dual_miss();
      test_reset_mid_walk();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
